// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU packet protocol (host and responder).
// Contents: opcode constants, header size, packet lengths, host state enum,
// and an opcode legality helper.
package uart_alu_pkg;

  localparam logic [7:0]  OP_ECHO   = 8'hEC;
  localparam logic [7:0]  OP_ADD    = 8'h01;
  localparam logic [7:0]  OP_MUL    = 8'h02;
  localparam logic [7:0]  OP_DIV    = 8'h03;

  localparam int unsigned HDR_BYTES = 4;
  // Total packet length including the 4-byte header.
  localparam logic [15:0] LEN_ARITH = 16'h000C;
  localparam logic [15:0] LEN_ECHO  = 16'h0008;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TX_HDR = 3'd1,
    TX_PAY = 3'd2,
    RX_RSP = 3'd3,
    RSP    = 3'd4
  } host_state_e;

  function automatic logic op_legal(input logic [7:0] op);
    return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/uart_alu_host_timer.sv
// Response-wait timer for uart_alu_host (used only when UART_ALU_HOST_TIMEOUT_EN is defined).
// Down-counter reloaded with TIMEOUT_CYCLES while load is high, decremented while en is high.
// Ports:
//   clk     in  clock
//   reset   in  synchronous active-high reset
//   load    in  reload counter with TIMEOUT_CYCLES
//   en      in  count enable
//   expired out terminal count reached (last counting cycle)
module uart_alu_host_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(TIMEOUT_CYCLES);
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Flags on the value 1 so the FSM leaves exactly TIMEOUT_CYCLES cycles after the load.
  assign expired = en && (count == W'(1));

endmodule

// File: rtl/uart_alu_host.sv
// Host-side initiator for the UART ALU packet protocol.
// Accepts one command, sends header + operand bytes to the uart transmitter,
// then gathers the 4-byte little-endian result from the uart receiver.
// Optional feature: define UART_ALU_HOST_TIMEOUT_EN to bound the response wait
// to TIMEOUT_CYCLES cycles (error response on expiry).
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o             command handshake
//   cmd_opcode_i, cmd_opa_i, cmd_opb_i  opcode and operands
//   tx_tdata_o/tx_tvalid_o/tx_tready_i  byte stream to uart transmitter
//   rx_tdata_i/rx_tvalid_i/rx_tready_o  byte stream from uart receiver
//   rsp_valid_o/rsp_ready_i             response handshake
//   rsp_data_o, rsp_err_o               result word, error flag
module uart_alu_host #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [7:0]            cmd_opcode_i,
  input  logic [31:0]           cmd_opa_i,
  input  logic [31:0]           cmd_opb_i,
  output logic [DATA_WIDTH-1:0] tx_tdata_o,
  output logic                  tx_tvalid_o,
  input  logic                  tx_tready_i,
  input  logic [DATA_WIDTH-1:0] rx_tdata_i,
  input  logic                  rx_tvalid_i,
  output logic                  rx_tready_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_data_o,
  output logic                  rsp_err_o
);

  import uart_alu_pkg::*;

  host_state_e state, state_nxt;
  logic [3:0]  cnt;
  logic [7:0]  opcode;
  logic [31:0] opa, opb;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        cmd_fire, tx_fire, rx_fire;
  logic        is_echo, last_pay, timeout_hit;
  logic [15:0] len;
  logic [31:0] pay_word;
  logic [7:0]  tx_byte;

  assign cmd_ready_o = (state == IDLE);
  assign tx_tvalid_o = (state == TX_HDR) || (state == TX_PAY);
  assign rx_tready_o = (state != RSP);
  assign rsp_valid_o = (state == RSP);
  assign rsp_data_o  = rsp_data;
  assign rsp_err_o   = rsp_err;
  assign tx_tdata_o  = tx_byte;

  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign tx_fire  = tx_tvalid_o && tx_tready_i;
  assign rx_fire  = rx_tvalid_i && rx_tready_o;

  assign is_echo  = (opcode == OP_ECHO);
  assign len      = is_echo ? LEN_ECHO : LEN_ARITH;
  assign last_pay = (cnt == (is_echo ? 4'd3 : 4'd7));
  assign pay_word = cnt[2] ? opb : opa;

`ifdef UART_ALU_HOST_TIMEOUT_EN
  // Reloads outside RX_RSP (clear on entry) and on every received byte.
  uart_alu_host_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk_i),
    .reset  (reset_i),
    .load   ((state != RX_RSP) || rx_fire),
    .en     (state == RX_RSP),
    .expired(timeout_hit)
  );
`else
  // No response-wait limit; the parameter is kept so both builds share one interface.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    tx_byte = '0;
    case (state)
      TX_HDR: begin
        case (cnt[1:0])
          2'd0:    tx_byte = opcode;
          2'd1:    tx_byte = 8'h00;
          2'd2:    tx_byte = len[7:0];
          default: tx_byte = len[15:8];
        endcase
      end
      TX_PAY:  tx_byte = pay_word[{cnt[1:0], 3'b000} +: 8];
      default: tx_byte = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (cmd_fire) state_nxt = op_legal(cmd_opcode_i) ? TX_HDR : RSP;
      TX_HDR: if (tx_fire && (cnt == 4'(HDR_BYTES - 1))) state_nxt = TX_PAY;
      TX_PAY: if (tx_fire && last_pay) state_nxt = RX_RSP;
      // A byte arriving on the expiry cycle takes precedence over the timeout.
      RX_RSP: begin
        if (rx_fire) begin
          if (cnt == 4'd3) state_nxt = RSP;
        end else if (timeout_hit) begin
          state_nxt = RSP;
        end
      end
      RSP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt      <= '0;
      opcode   <= '0;
      opa      <= '0;
      opb      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (tx_fire || (rx_fire && (state == RX_RSP))) begin
        cnt <= cnt + 4'd1;
      end

      if (cmd_fire) begin
        opcode   <= cmd_opcode_i;
        opa      <= cmd_opa_i;
        opb      <= cmd_opb_i;
        rsp_data <= '0;
        rsp_err  <= !op_legal(cmd_opcode_i);
      end

      if (state == RX_RSP) begin
        if (rx_fire) begin
          // Little-endian: first byte ends up in bits [7:0] after four shifts.
          rsp_data <= {rx_tdata_i, rsp_data[31:8]};
        end else if (timeout_hit) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_host.sv
module tb_uart_alu_host;

  logic        clk;
  logic        reset_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_opcode_i;
  logic [31:0] cmd_opa_i;
  logic [31:0] cmd_opb_i;
  logic [7:0]  tx_tdata_o;
  logic        tx_tvalid_o;
  logic        tx_tready_i;
  logic [7:0]  rx_tdata_i;
  logic        rx_tvalid_i;
  logic        rx_tready_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  txq[$];
  logic [32:0] rspq[$];

  uart_alu_host #(
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i),
    .cmd_opa_i   (cmd_opa_i),
    .cmd_opb_i   (cmd_opb_i),
    .tx_tdata_o  (tx_tdata_o),
    .tx_tvalid_o (tx_tvalid_o),
    .tx_tready_i (tx_tready_i),
    .rx_tdata_i  (rx_tdata_i),
    .rx_tvalid_i (rx_tvalid_i),
    .rx_tready_o (rx_tready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      8'h01:   return a + b;
      8'h02:   return a * b;
      8'h03:   return $unsigned($signed(a) / $signed(b));
      default: return a;
    endcase
  endfunction

  // Drives one command and records the expected tx bytes and response.
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_timeout);
    bit legal;
    legal = (op == 8'hEC) || (op == 8'h01) || (op == 8'h02) || (op == 8'h03);
    if (legal) begin
      txq.push_back(op);
      txq.push_back(8'h00);
      txq.push_back((op == 8'hEC) ? 8'h08 : 8'h0C);
      txq.push_back(8'h00);
      for (int i = 0; i < 4; i++) txq.push_back(a[8*i +: 8]);
      if (op != 8'hEC)
        for (int i = 0; i < 4; i++) txq.push_back(b[8*i +: 8]);
      if (expect_timeout) rspq.push_back({1'b1, 32'h0});
      else                rspq.push_back({1'b0, model(op, a, b)});
    end else begin
      rspq.push_back({1'b1, 32'h0});
    end
    cmd_opcode_i = op;
    cmd_opa_i    = a;
    cmd_opb_i    = b;
    cmd_valid_i  = 1'b1;
    chk("cmd_ready_idle", 64'(cmd_ready_o), 64'(1));
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("cmd_ready_busy", 64'(cmd_ready_o), 64'(0));
    if (legal) chk("tx_valid_rise", 64'(tx_tvalid_o), 64'(1));
  endtask

  task automatic drain_tx(input bit toggle, input int max_bytes);
    int   sent = 0;
    int   cyc = 0;
    bit   ph = 1'b0;
    bit   stalled = 1'b0;
    logic [7:0] held = 8'h00;
    while (sent < max_bytes && txq.size() > 0 && cyc < 400) begin
      tx_tready_i = toggle ? ph : 1'b1;
      ph = ~ph;
      if (stalled) chk("tx_hold", 64'({tx_tvalid_o, tx_tdata_o}), 64'({1'b1, held}));
      if (tx_tvalid_o) begin
        if (tx_tready_i) begin
          chk("tx_byte", 64'(tx_tdata_o), 64'(txq.pop_front()));
          sent++;
          stalled = 1'b0;
        end else begin
          held    = tx_tdata_o;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    tx_tready_i = 1'b1;
  endtask

  task automatic rx_rsp(input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      rx_tdata_i  = word[8*i +: 8];
      rx_tvalid_i = 1'b1;
      if (i == 0) chk("rx_ready_wait", 64'(rx_tready_o), 64'(1));
      @(negedge clk);
    end
    rx_tvalid_i = 1'b0;
    chk("rsp_rise", 64'(rsp_valid_o), 64'(1));
    chk("rx_ready_rsp", 64'(rx_tready_o), 64'(0));
  endtask

  task automatic take_rsp(input int hold);
    logic [32:0] exp;
    chk("rsp_queue_nonempty", 64'(rspq.size() > 0), 64'(1));
    exp = (rspq.size() > 0) ? rspq.pop_front() : 33'h0;
    chk("rsp_result", 64'({rsp_valid_o, rsp_err_o, rsp_data_o}), 64'({1'b1, exp}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_stable", 64'({rsp_valid_o, rsp_err_o, rsp_data_o}), 64'({1'b1, exp}));
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("rsp_drop", 64'(rsp_valid_o), 64'(0));
    chk("cmd_ready_back", 64'(cmd_ready_o), 64'(1));
  endtask

  task automatic full_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit toggle);
    issue(op, a, b, 1'b0);
    drain_tx(toggle, 99);
    chk("tx_all_sent", 64'(txq.size()), 64'(0));
    chk("tx_idle_after", 64'(tx_tvalid_o), 64'(0));
    rx_rsp(model(op, a, b));
    take_rsp(0);
  endtask

  initial begin
    int n;
    reset_i      = 1'b1;
    cmd_valid_i  = 1'b0;
    cmd_opcode_i = 8'h00;
    cmd_opa_i    = 32'h0;
    cmd_opb_i    = 32'h0;
    tx_tready_i  = 1'b1;
    rx_tdata_i   = 8'h00;
    rx_tvalid_i  = 1'b0;
    rsp_ready_i  = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
    chk("rst_tx_valid",  64'(tx_tvalid_o), 64'(0));
    chk("rst_tx_data",   64'(tx_tdata_o),  64'(0));
    chk("rst_rx_ready",  64'(rx_tready_o), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk("rst_rsp_data",  64'(rsp_data_o),  64'(0));
    chk("rst_rsp_err",   64'(rsp_err_o),   64'(0));
    reset_i = 1'b0;
    @(negedge clk);

    // Stray bytes while idle must be consumed and ignored.
    rx_tdata_i  = 8'hAA;
    rx_tvalid_i = 1'b1;
    chk("rx_ready_idle", 64'(rx_tready_o), 64'(1));
    repeat (2) @(negedge clk);
    rx_tvalid_i = 1'b0;
    chk("idle_no_rsp", 64'(rsp_valid_o), 64'(0));

    full_cmd(8'h01, 32'd5, 32'd7, 1'b0);
    full_cmd(8'hEC, 32'hDEADBEEF, 32'h12345678, 1'b0);
    full_cmd(8'h02, 32'hFFFFFFFD, 32'd4, 1'b1);

    // Illegal opcode: no tx, error response the cycle after accept.
    issue(8'h55, 32'h11111111, 32'h22222222, 1'b0);
    chk("bad_op_no_tx", 64'(tx_tvalid_o), 64'(0));
    chk("bad_op_rsp", 64'({rsp_valid_o, rsp_err_o}), 64'(2'b11));
    take_rsp(5);

`ifdef UART_ALU_HOST_TIMEOUT_EN
    issue(8'h03, 32'd100, 32'd7, 1'b1);
    drain_tx(1'b0, 99);
    chk("tx_all_sent_to", 64'(txq.size()), 64'(0));
    n = 0;
    while (!rsp_valid_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'(100));
    take_rsp(0);
`else
    issue(8'h03, 32'd100, 32'd7, 1'b0);
    drain_tx(1'b0, 99);
    chk("tx_all_sent_wait", 64'(txq.size()), 64'(0));
    n = 0;
    repeat (300) begin
      @(negedge clk);
      n++;
    end
    chk("no_timeout_wait", 64'({rsp_valid_o, rx_tready_o}), 64'(2'b01));
    rx_rsp(model(8'h03, 32'd100, 32'd7));
    take_rsp(0);
`endif

    // Reset after five bytes have gone out (first payload byte): abort cleanly.
    issue(8'h01, 32'hAAAA5555, 32'h0000FFFF, 1'b0);
    drain_tx(1'b0, 5);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("rst_mid_tx_valid", 64'(tx_tvalid_o), 64'(0));
    chk("rst_mid_cmd_ready", 64'(cmd_ready_o), 64'(1));
    chk("rst_mid_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_data_o}), 64'(0));
    txq.delete();
    rspq.delete();

    full_cmd(8'h01, 32'h12345678, 32'h0F0F0F0F, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
